serial_transmitter: RTL and testbench
=====================================

Name: serial_transmitter

Overview:
Serial transmit engine for the CPU-facing serial peripheral. It is the outgoing counterpart of the receive path. CPU writes to the data register push bytes into a small internal FIFO. The block serialises each byte onto TX as an 8N1 frame (start bit, 8 data bits LSB first, stop bit), timed by the programmed baud divisor. Status outputs feed the status register and interrupt logic.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
DATA_W, 8, bits per character (fixed at 8 for 8N1; parameterised for the shift counter width)

Ports:
CLK  input  1  system clock, all state on rising edge
RESET  input  1  synchronous, active-high reset
ENABLE  input  1  serial enable (status bit 0); gates the start of new frames
BAUD  input  8  baud divisor; bit period = BAUD+1 CLK cycles
LOAD  input  1  one-cycle write strobe (decoded data-register write)
DATA_IN  input  8  byte to enqueue, sampled when LOAD=1
CLR_ERR  input  1  clears OVERRUN
TX  output  1  serial line, idle high
BUSY  output  1  frame in progress (state != IDLE)
TX_EMPTY  output  1  FIFO empty and state IDLE
FULL  output  1  FIFO holds DEPTH entries
COUNT  output  $clog2(DEPTH)+1  FIFO occupancy
OVERRUN  output  1  sticky: LOAD while FULL with no same-cycle pop

Behaviour:
- Reset values: TX=1, BUSY=0, TX_EMPTY=1, FULL=0, COUNT=0, OVERRUN=0. FIFO pointers=0. State=IDLE. Baud counter=0.
- Reset mid-frame: TX returns to 1 on the reset edge. The frame is abandoned and the FIFO is flushed.
- FIFO: circular buffer with read/write pointers and an occupancy counter.
  - LOAD && !FULL: write at wptr, COUNT+1.
  - LOAD && FULL && pop in the same cycle: push accepted, COUNT unchanged.
  - LOAD && FULL && no pop: byte dropped, OVERRUN<=1.
  - CLR_ERR clears OVERRUN. If CLR_ERR and a new overrun occur in the same cycle, the set wins.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, START, DATA, STOP. TX is registered.
  - IDLE: if ENABLE && COUNT!=0, pop the head into the shift register, latch BAUD into the bit-period register, clear the baud counter, and go to START with TX<=0.
  - A byte loaded at edge k into an empty FIFO with the FSM idle is popped at edge k+1. TX is low from edge k+1.
  - START: hold TX=0 for BAUD+1 cycles, then go to DATA with TX<=shift[0] and bit index 0.
  - DATA: each bit is held BAUD+1 cycles. At period end, shift right and increment the index. After bit 7, go to STOP with TX<=1.
  - STOP: hold TX=1 for BAUD+1 cycles. At period end:
    - if ENABLE && COUNT!=0, pop and go directly to START (no idle gap between frames);
    - otherwise go to IDLE.
- Baud counter counts 0..latched BAUD. The period ends when the counter equals latched BAUD; the counter then resets to 0. BAUD=0 gives one CLK per bit.
- BAUD changes mid-frame take effect on the next frame only.
- ENABLE deasserted mid-frame: the current frame completes and no new frame starts. The FIFO contents are retained.
- Frame length is exactly 10*(BAUD+1) cycles.
- BUSY=1 in START/DATA/STOP.
- TX_EMPTY and FULL are combinational from COUNT and state.

Decomposition:
- Shared package serial_pkg: state enum tx_state_t {IDLE, START, DATA, STOP}, constants FRAME_BITS=10, DATA_BITS=8. The future receive rewrite shares this package.
- Sub-module tx_fifo (DEPTH, DATA_W): push/pop/full/count/overrun. The top level holds the FSM, shift register and baud counter.

Test Plan:
1. BAUD=3, ENABLE=1, LOAD 0xA5 → from the edge after LOAD, TX=0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total). BUSY is high throughout, then TX_EMPTY=1.
2. BAUD=0, LOAD 0x00 then 0xFF on consecutive cycles → 20 contiguous bit cycles with no idle gap between stop bit and second start bit. COUNT peaks at 1.
3. ENABLE=0, LOAD 5 bytes (DEPTH=4) → COUNT=4, FULL=1, OVERRUN=1, TX stays 1. Assert CLR_ERR → OVERRUN=0. Set ENABLE=1 → the first 4 bytes are sent in order.
4. BAUD=2, mid-DATA change BAUD to 7 → the current frame keeps 3-cycle bits. The next queued frame uses 8-cycle bits.
5. RESET asserted during bit 4 of a frame with 2 bytes queued → next cycle TX=1, BUSY=0, COUNT=0, TX_EMPTY=1. No further frames are sent.
6. FULL with the FSM popping on the same edge as LOAD → the byte is accepted, COUNT stays 4, OVERRUN stays 0.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared serial-peripheral definitions.
// Used by the transmit engine and intended for reuse by the receive path.
//   tx_state_t : transmit FSM state encoding
//   FRAME_BITS : bits per 8N1 frame (start + data + stop)
//   DATA_BITS  : data bits per character
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = 8;

endpackage

// File: rtl/tx_fifo.sv
// Circular transmit FIFO with an occupancy counter and a sticky overrun flag.
//   clk, reset : clock, synchronous active-high reset (flushes contents)
//   push, din  : enqueue strobe and byte
//   pop, dout  : dequeue strobe and head-of-queue byte (dout is combinational)
//   clr_err    : clears overrun; a same-cycle new overrun wins
//   full       : count == DEPTH
//   count      : occupancy 0..DEPTH
//   overrun    : set by a push while full with no same-cycle pop
module tx_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [DATA_W-1:0]        din,
    input  logic                     pop,
    output logic [DATA_W-1:0]        dout,
    input  logic                     clr_err,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overrun
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic              push_ok;

    assign full    = (count == CW'(DEPTH));
    // A pop on the same edge frees the slot, so a push while full still lands.
    assign push_ok = push && (!full || pop);
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push_ok)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;

            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (push && !push_ok)
                overrun <= 1'b1;
            else if (clr_err)
                overrun <= 1'b0;
        end
    end

endmodule

// File: rtl/serial_transmitter.sv
// 8N1 serial transmit engine: FIFO-buffered bytes are framed as
// start(0), 8 data bits LSB first, stop(1); each bit lasts BAUD+1 CLK cycles.
//   CLK, RESET : clock, synchronous active-high reset
//   ENABLE     : allows new frames to start (a running frame always completes)
//   BAUD       : bit period minus one, latched at frame start
//   LOAD       : write strobe enqueueing DATA_IN
//   CLR_ERR    : clears OVERRUN
//   TX         : registered serial line, idle high
//   BUSY       : frame in progress
//   TX_EMPTY   : FIFO empty and no frame in progress
//   FULL, COUNT, OVERRUN : FIFO status
module serial_transmitter
    import serial_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = DATA_BITS
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   ENABLE,
    input  logic [7:0]             BAUD,
    input  logic                   LOAD,
    input  logic [DATA_W-1:0]      DATA_IN,
    input  logic                   CLR_ERR,
    output logic                   TX,
    output logic                   BUSY,
    output logic                   TX_EMPTY,
    output logic                   FULL,
    output logic [$clog2(DEPTH):0] COUNT,
    output logic                   OVERRUN
);

    localparam int              IW       = $clog2(DATA_W);
    localparam logic [IW-1:0]   LAST_IDX = IW'(DATA_W - 1);

    tx_state_t         state;
    tx_state_t         state_nx;
    logic [DATA_W-1:0] shift;
    logic [DATA_W-1:0] fifo_dout;
    logic [7:0]        bit_period;
    logic [7:0]        baud_cnt;
    logic [IW-1:0]     bit_idx;
    logic              period_end;
    logic              have_data;
    logic              pop;

    tx_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk     (CLK),
        .reset   (RESET),
        .push    (LOAD),
        .din     (DATA_IN),
        .pop     (pop),
        .dout    (fifo_dout),
        .clr_err (CLR_ERR),
        .full    (FULL),
        .count   (COUNT),
        .overrun (OVERRUN)
    );

    assign have_data  = ENABLE && (COUNT != '0);
    assign period_end = (baud_cnt == bit_period);

    // State register
    always_ff @(posedge CLK) begin
        if (RESET)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next state; pop marks the edge where a new frame is loaded
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                if (have_data) begin
                    state_nx = START;
                    pop      = 1'b1;
                end
            end
            START: begin
                if (period_end)
                    state_nx = DATA;
            end
            DATA: begin
                if (period_end && bit_idx == LAST_IDX)
                    state_nx = STOP;
            end
            STOP: begin
                if (period_end) begin
                    // Back-to-back frames: next start bit follows the stop bit directly.
                    if (have_data) begin
                        state_nx = START;
                        pop      = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Status outputs
    always_comb begin
        BUSY     = (state != IDLE);
        TX_EMPTY = (state == IDLE) && (COUNT == '0);
    end

    // Bit timing, shift register and the registered line
    always_ff @(posedge CLK) begin
        if (RESET) begin
            TX         <= 1'b1;
            shift      <= '0;
            bit_period <= '0;
            baud_cnt   <= '0;
            bit_idx    <= '0;
        end else if (pop) begin
            shift      <= fifo_dout;
            bit_period <= BAUD;      // later BAUD writes wait for the next frame
            baud_cnt   <= '0;
            TX         <= 1'b0;
        end else if (state != IDLE) begin
            if (!period_end) begin
                baud_cnt <= baud_cnt + 1'b1;
            end else begin
                baud_cnt <= '0;
                case (state)
                    START: begin
                        TX      <= shift[0];
                        bit_idx <= '0;
                    end
                    DATA: begin
                        shift   <= shift >> 1;
                        bit_idx <= bit_idx + 1'b1;
                        TX      <= (bit_idx == LAST_IDX) ? 1'b1 : shift[1];
                    end
                    default: TX <= 1'b1;   // stop bit ended with nothing to send
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_transmitter.sv
module tb_serial_transmitter;

    localparam int DEPTH = 4;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       ENABLE = 1'b0;
    logic [7:0] BAUD = 8'd0;
    logic       LOAD = 1'b0;
    logic [7:0] DATA_IN = 8'd0;
    logic       CLR_ERR = 1'b0;
    logic       TX, BUSY, TX_EMPTY, FULL, OVERRUN;
    logic [2:0] COUNT;

    int errors = 0;
    int checks = 0;

    serial_transmitter #(.DEPTH(DEPTH), .DATA_W(8)) dut (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .BAUD(BAUD),
        .LOAD(LOAD), .DATA_IN(DATA_IN), .CLR_ERR(CLR_ERR),
        .TX(TX), .BUSY(BUSY), .TX_EMPTY(TX_EMPTY), .FULL(FULL),
        .COUNT(COUNT), .OVERRUN(OVERRUN)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (frame-level) ----------------
    typedef struct {
        logic       tx;
        logic       busy;
        logic       empty;
        logic       full;
        logic       ovr;
        logic [2:0] cnt;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] mq[$];
    bit         m_in = 0;
    int         m_t = 0;
    int         m_per = 1;
    logic [9:0] m_bits = '1;
    bit         m_ovr = 0;

    // The line during a frame is simply frame bit (elapsed / period).
    always @(posedge CLK) begin
        exp_t       e;
        bit         fin;
        bit         popm;
        logic [7:0] b;
        if (RESET) begin
            mq.delete();
            m_in  = 0;
            m_t   = 0;
            m_ovr = 0;
        end else begin
            fin  = m_in && (m_t == 10 * m_per - 1);
            popm = (!m_in || fin) && ENABLE && (mq.size() > 0);
            if (m_in) begin
                m_t++;
                if (fin) m_in = 0;
            end
            if (popm) begin
                b      = mq.pop_front();
                m_bits = {1'b1, b, 1'b0};
                m_per  = int'(BAUD) + 1;
                m_t    = 0;
                m_in   = 1;
            end
            if (CLR_ERR) m_ovr = 0;
            if (LOAD) begin
                if (mq.size() < DEPTH) mq.push_back(DATA_IN);
                else m_ovr = 1;
            end
        end
        e.tx    = m_in ? m_bits[m_t / m_per] : 1'b1;
        e.busy  = m_in;
        e.empty = !m_in && (mq.size() == 0);
        e.full  = (mq.size() == DEPTH);
        e.ovr   = m_ovr;
        e.cnt   = 3'(mq.size());
        exp_q.push_back(e);
    end

    // ---------------- monitor ----------------
    always @(negedge CLK) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_tx",       TX,       e.tx);
            chk("sb_busy",     BUSY,     e.busy);
            chk("sb_tx_empty", TX_EMPTY, e.empty);
            chk("sb_full",     FULL,     e.full);
            chk("sb_overrun",  OVERRUN,  e.ovr);
            chk("sb_count",    COUNT,    e.cnt);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_empty(input int maxc);
        int n = 0;
        while (!TX_EMPTY && n < maxc) begin
            cyc(1);
            n++;
        end
        chk("drain_timeout", TX_EMPTY, 1'b1);
    endtask

    initial begin : stim
        logic [9:0] pat;
        int         peak;

        cyc(3);
        chk("reset_tx", TX, 1'b1);
        chk("reset_busy", BUSY, 1'b0);
        chk("reset_empty", TX_EMPTY, 1'b1);
        chk("reset_count", COUNT, 3'd0);
        RESET = 1'b0;
        cyc(2);

        // 1: single 0xA5 at BAUD=3
        BAUD = 8'd3; ENABLE = 1'b1;
        LOAD = 1'b1; DATA_IN = 8'hA5;
        cyc(1);
        LOAD = 1'b0;
        cyc(1);
        pat = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 40; i++) begin
            chk("t1_tx", TX, pat[i / 4]);
            chk("t1_busy", BUSY, 1'b1);
            cyc(1);
        end
        chk("t1_empty_after", TX_EMPTY, 1'b1);
        cyc(3);

        // 2: back-to-back at BAUD=0
        BAUD = 8'd0;
        LOAD = 1'b1; DATA_IN = 8'h00;
        cyc(1);
        DATA_IN = 8'hFF;
        cyc(1);
        LOAD = 1'b0;
        peak = 0;
        for (int i = 0; i < 20; i++) begin
            chk("t2_busy", BUSY, 1'b1);
            if (int'(COUNT) > peak) peak = int'(COUNT);
            cyc(1);
        end
        chk("t2_count_peak", peak, 1);
        chk("t2_empty", TX_EMPTY, 1'b1);
        cyc(2);

        // 3 + 6: fill while disabled, overrun, clear, then push on the pop edge
        ENABLE = 1'b0; BAUD = 8'd1;
        for (int i = 0; i < 5; i++) begin
            LOAD = 1'b1; DATA_IN = 8'(8'h11 * (i + 1));
            cyc(1);
        end
        LOAD = 1'b0;
        chk("t3_count", COUNT, 3'd4);
        chk("t3_full", FULL, 1'b1);
        chk("t3_overrun", OVERRUN, 1'b1);
        chk("t3_tx_idle", TX, 1'b1);
        CLR_ERR = 1'b1;
        cyc(1);
        CLR_ERR = 1'b0;
        chk("t3_overrun_clr", OVERRUN, 1'b0);
        ENABLE = 1'b1; LOAD = 1'b1; DATA_IN = 8'h5A;
        cyc(1);
        LOAD = 1'b0;
        chk("t6_count", COUNT, 3'd4);
        chk("t6_overrun", OVERRUN, 1'b0);
        chk("t6_busy", BUSY, 1'b1);
        wait_empty(200);
        cyc(2);

        // 4: BAUD change mid-frame affects only the next frame
        BAUD = 8'd2;
        LOAD = 1'b1; DATA_IN = 8'h3C;
        cyc(1);
        DATA_IN = 8'hC3;
        cyc(1);
        LOAD = 1'b0;
        cyc(12);
        BAUD = 8'd7;
        wait_empty(200);
        cyc(2);

        // 5: reset during data bit 4 with two bytes queued
        BAUD = 8'd1;
        LOAD = 1'b1; DATA_IN = 8'h96;
        cyc(1);
        DATA_IN = 8'h21;
        cyc(1);
        DATA_IN = 8'h42;
        cyc(1);
        LOAD = 1'b0;
        cyc(9);
        chk("t5_busy_before", BUSY, 1'b1);
        RESET = 1'b1;
        cyc(1);
        RESET = 1'b0;
        chk("t5_tx", TX, 1'b1);
        chk("t5_busy", BUSY, 1'b0);
        chk("t5_count", COUNT, 3'd0);
        chk("t5_empty", TX_EMPTY, 1'b1);
        cyc(40);
        chk("t5_no_frame", TX, 1'b1);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            LOAD    = ($urandom_range(0, 3) == 0);
            DATA_IN = 8'($urandom);
            CLR_ERR = ($urandom_range(0, 15) == 0);
            ENABLE  = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 199) == 0) BAUD = 8'($urandom_range(0, 3));
            RESET   = ($urandom_range(0, 999) == 0);
            cyc(1);
        end
        LOAD = 1'b0; CLR_ERR = 1'b0; RESET = 1'b0; ENABLE = 1'b1;
        wait_empty(300);
        cyc(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
